// File: rtl/mcp3x08_scanner.sv
`default_nettype none
// ============================================================================
// Module   : mcp3x08_scanner
// Brief    : Round-robin SPI scanner for MCP3008 (10-bit) / MCP3208 (12-bit)
//            ADCs. Walks a run-time channel mask, optionally averages
//            2^AVG_LOG2 back-to-back conversions per channel and publishes
//            per-channel results with one-cycle valid strobes.
// Revision : 1.0 - initial release
// ============================================================================
module mcp3x08_scanner #(
  parameter int CLK_DIV  = 675,
  parameter int NUM_CH   = 8,
  parameter int RES_BITS = 10,
  parameter int AVG_LOG2 = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [NUM_CH-1:0]            ch_mask,
  output logic                         sclk,
  output logic                         cs_n,
  output logic                         mosi,
  input  logic                         miso,
  output logic [NUM_CH*RES_BITS-1:0]   sample_data,
  output logic [NUM_CH-1:0]            sample_valid,
  output logic                         scan_done,
  output logic                         busy
);

  // SCLK pulses per frame: start, SGL, D2..D0, sample window, null bit, data
  localparam int N_PULSES = 7 + RES_BITS;
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DIV_W    = $clog2(CLK_DIV);
  localparam int HALF_W   = $clog2(2 * N_PULSES);
  localparam int GAP_W    = $clog2(2 * CLK_DIV);
  localparam int ACC_W    = RES_BITS + AVG_LOG2;
  localparam int AVG_W    = AVG_LOG2 + 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * N_PULSES - 1);
  // Half-period index of rising edge 8, the first data-bearing edge
  localparam logic [HALF_W-1:0] CAP_FIRST = HALF_W'(14);
  // GAP lasts 2D-2 cycles; together with PUBLISH and START the CS-high gap is 2D
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(2 * CLK_DIV - 3);
  localparam logic [AVG_W-1:0]  AVG_LAST  = AVG_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    SHIFT   = 3'd2,
    PUBLISH = 3'd3,
    GAP     = 3'd4
  } state_t;

  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic [HALF_W-1:0]   half_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [CH_W-1:0]     cur_ch;
  logic [CH_W-1:0]     last_ch;
  logic [CH_W-1:0]     top_ch;
  logic [RES_BITS-1:0] shift_data;
  logic [ACC_W-1:0]    acc;
  logic [AVG_W-1:0]    avg_cnt;
  logic                avg_done;
  logic                miso_meta;
  logic                miso_sync;

  logic                sel_found;
  logic [CH_W-1:0]     sel_ch;
  logic [CH_W-1:0]     mask_top;
  logic [ACC_W-1:0]    sum_next;
  logic [RES_BITS-1:0] avg_value;
  logic [2:0]          addr;

  assign addr      = 3'(cur_ch);
  assign sum_next  = acc + ACC_W'(shift_data);
  assign avg_value = RES_BITS'(sum_next >> AVG_LOG2);

  // Next enabled channel strictly after the last completed one, wrapping
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    for (int off = 1; off <= NUM_CH; off++) begin
      if (!sel_found && ch_mask[(int'(last_ch) + off) % NUM_CH]) begin
        sel_found = 1'b1;
        sel_ch    = CH_W'((int'(last_ch) + off) % NUM_CH);
      end
    end
  end

  // Highest enabled channel in the current mask; marks the end of a scan
  always_comb begin
    mask_top = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_mask[i]) begin
        mask_top = CH_W'(i);
      end
    end
  end

  // Two-flop synchroniser for the asynchronous ADC data line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_meta <= 1'b0;
      miso_sync <= 1'b0;
    end else begin
      miso_meta <= miso;
      miso_sync <= miso_meta;
    end
  end

  // Frame sequencer: SPI waveform, data capture, averaging and publishing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cs_n         <= 1'b1;
      sclk         <= 1'b0;
      mosi         <= 1'b0;
      sample_data  <= '0;
      sample_valid <= '0;
      scan_done    <= 1'b0;
      busy         <= 1'b0;
      div_cnt      <= '0;
      half_cnt     <= '0;
      gap_cnt      <= '0;
      cur_ch       <= '0;
      last_ch      <= CH_W'(NUM_CH - 1);
      top_ch       <= '0;
      shift_data   <= '0;
      acc          <= '0;
      avg_cnt      <= '0;
      avg_done     <= 1'b0;
    end else begin
      sample_valid <= '0;
      scan_done    <= 1'b0;
      case (state)
        IDLE: begin
          cs_n <= 1'b1;
          sclk <= 1'b0;
          mosi <= 1'b0;
          busy <= 1'b0;
          if (enable && sel_found) begin
            cur_ch <= sel_ch;
            top_ch <= mask_top;
            busy   <= 1'b1;
            state  <= START;
          end
        end

        START: begin
          // This edge is the frame origin: CS low, start bit on mosi
          cs_n       <= 1'b0;
          sclk       <= 1'b0;
          mosi       <= 1'b1;
          div_cnt    <= '0;
          half_cnt   <= '0;
          shift_data <= '0;
          state      <= SHIFT;
        end

        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            half_cnt <= half_cnt + 1'b1;
            if (!half_cnt[0]) begin
              // Rising edge; data bits arrive from edge 8 onwards
              sclk <= 1'b1;
              if (half_cnt >= CAP_FIRST) begin
                shift_data <= {shift_data[RES_BITS-2:0], miso_sync};
              end
            end else begin
              sclk <= 1'b0;
              if (half_cnt == HALF_LAST) begin
                // Last falling edge doubles as end of frame
                cs_n  <= 1'b1;
                mosi  <= 1'b0;
                state <= PUBLISH;
                if (avg_cnt == AVG_LAST) begin
                  for (int i = 0; i < NUM_CH; i++) begin
                    if (cur_ch == CH_W'(i)) begin
                      sample_data[i*RES_BITS +: RES_BITS] <= avg_value;
                      sample_valid[i]                     <= 1'b1;
                    end
                  end
                  scan_done <= (cur_ch == top_ch);
                  last_ch   <= cur_ch;
                  acc       <= '0;
                  avg_cnt   <= '0;
                  avg_done  <= 1'b1;
                end else begin
                  acc      <= sum_next;
                  avg_cnt  <= avg_cnt + 1'b1;
                  avg_done <= 1'b0;
                end
              end else if (half_cnt == HALF_W'(1)) begin
                mosi <= 1'b1;
              end else if (half_cnt == HALF_W'(3)) begin
                mosi <= addr[2];
              end else if (half_cnt == HALF_W'(5)) begin
                mosi <= addr[1];
              end else if (half_cnt == HALF_W'(7)) begin
                mosi <= addr[0];
              end else begin
                mosi <= 1'b0;
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        PUBLISH: begin
          gap_cnt <= '0;
          state   <= GAP;
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (!enable) begin
              // Scanning withdrawn: a partial average is meaningless later
              state   <= IDLE;
              busy    <= 1'b0;
              acc     <= '0;
              avg_cnt <= '0;
            end else if (!avg_done) begin
              state <= START;
            end else if (sel_found) begin
              cur_ch <= sel_ch;
              top_ch <= mask_top;
              state  <= START;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mcp3x08_scanner.md
# mcp3x08_scanner

Parametrised SPI scanner for MCP3008 (10-bit) / MCP3208 (12-bit) ADCs. It replaces the fixed 32-slot ADC sequencer inside the motor-control clock domain. It round-robins over a run-time channel mask, optionally averages 2^AVG_LOG2 consecutive conversions per channel, and publishes per-channel results with one-cycle valid strobes. Downstream consumers are throttle/accel shaping, battery monitoring and CAN telemetry.

## Interface
Parameters:
- CLK_DIV, 675: clk cycles per SCLK half-period; minimum 2.
- NUM_CH, 8: number of channels, 1..8; channel index i is ADC address i.
- RES_BITS, 10: conversion width, 10 (MCP3008) or 12 (MCP3208).
- AVG_LOG2, 0: back-to-back conversions per channel are 2^AVG_LOG2; range 0..4.

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  scanning permitted.
- ch_mask  in  NUM_CH  channels to scan; bit i enables channel i.
- sclk  out  1  SPI clock; idles low.
- cs_n  out  1  ADC chip select, active low.
- mosi  out  1  command bits to the ADC (DIN).
- miso  in  1  ADC data (DOUT); asynchronous, so two-flop synchronised.
- sample_data  out  NUM_CH*RES_BITS  per-channel results; slice i is [i*RES_BITS +: RES_BITS].
- sample_valid  out  NUM_CH  1-clk pulse on bit i when slice i is updated.
- scan_done  out  1  1-clk pulse when the highest-indexed enabled channel publishes.
- busy  out  1  high while cs_n is low or during the CS-high gap between frames.

## Operation
- Reset values: cs_n=1, sclk=0, mosi=0, sample_data=0, sample_valid=0, scan_done=0, busy=0. Averaging state is cleared.
- FSM states:
  - IDLE -> START when enable=1 and ch_mask!=0.
  - START -> SHIFT.
  - SHIFT -> PUBLISH.
  - PUBLISH -> GAP.
  - GAP -> START, or GAP -> IDLE.
- Channel selection:
  - Occurs in IDLE/GAP.
  - Pick the next set ch_mask bit with index strictly greater than the last completed channel, ascending, wrapping to 0.
  - After reset, the search starts at index 0.
  - ch_mask is sampled only at channel selection. Mask changes mid-frame or mid-average take effect at the next selection.
- Command frame (MCP3x08 single-ended), MSB first on mosi: start=1, SGL=1, D2, D1, D0.
- Data: the ADC emits a null bit, then B[RES_BITS-1]..B0. The null bit is discarded.
- Averaging:
  - The selected channel is converted 2^AVG_LOG2 times back to back.
  - The conversions are summed in an unsigned accumulator of RES_BITS+AVG_LOG2 bits.
  - The published value is sum >> AVG_LOG2 (truncating).
  - With AVG_LOG2=0, every frame publishes.
- Publish: update slice i and pulse sample_valid[i] on the same clk edge. Pulse scan_done on that edge if i is the highest set bit of the mask latched at selection.
- enable deasserted mid-frame or mid-average: the current frame completes. Its sample enters the accumulator but nothing publishes unless the average is complete. Then go IDLE and discard the accumulator.
- ch_mask==0 with enable=1: stay in IDLE; cs_n stays 1 and busy stays 0.
- Reset asserted mid-frame: outputs take reset values immediately (asynchronous). No valid or scan_done pulse is issued.

## Timing
- Let D=CLK_DIV, N=7+RES_BITS (SCLK pulses per frame), and S be the clk edge that starts a frame.
- At S: cs_n=0, sclk=0, mosi=1 (start bit).
- Rising edge k (k=1..N): sclk goes high at S+(2k-1)D.
- Falling edge k: sclk goes low at S+2kD.
- mosi changes only at falling edges:
  - After falling edge 1..4, mosi = SGL, D2, D1, D0.
  - After falling edge 5, mosi=0 for the rest of the frame.
- miso capture:
  - The synchronised miso is captured at the clk edge that raises sclk, for k=8..N.
  - Edge 8 captures B[RES_BITS-1]; edge N captures B0.
  - Synchroniser latency is 2 clk, so D>=3 is required for margin. D=2 is legal only with a 0 ns board model.
- End of frame at S+2ND: cs_n=1. If the average is complete, publish at this edge.
- Next frame starts at S+2ND+2D (gap of 2D clk with cs_n=1, busy=1).
- Default frame length: 2*675*17 = 22950 clk, plus a 1350-clk gap.

## Test plan
- Reset: hold rst_n=0, toggle clk/miso -> all outputs at reset values. Release -> cs_n stays 1 while ch_mask=0.
- Single channel, D=4, ch_mask=8'h20, ADC model returns 10'h2A5:
  - mosi bits 1,1,1,0,1.
  - cs_n low for exactly 136 clk.
  - slice 5 = 10'h2A5, sample_valid=8'h20 for 1 clk, scan_done pulses with it.
- Round robin, ch_mask=8'h83:
  - Order 0,1,7,0,1.
  - Frame starts 144 clk apart.
  - scan_done pulses only with channel 7.
  - Mask changed to 8'h04 mid-frame -> applies at the next selection.
- Averaging, AVG_LOG2=2, channel 3, model returns 100,101,102,105:
  - One publish after the 4th frame; slice 3 = 102.
  - No sample_valid pulses before the 4th frame.
- enable dropped at sclk rising edge 3:
  - The frame runs to S+2ND and publishes (AVG_LOG2=0).
  - Then cs_n stays 1 and busy returns to 0 after the gap.
- rst_n pulsed low at rising edge 10; RES_BITS=12 variant:
  - cs_n=1 and sclk=0 immediately, with no pulses.
  - After release, the model returns 12'hABC -> slice 0 = 12'hABC and N=19 pulses counted.
